sub_bytes_engine: RTL and testbench

//  Multi-cycle AES SubBytes / InvSubBytes engine for a 128-bit state.

---
 rtl/sub_bytes_if.sv | 13 +
 rtl/sub_bytes_engine.sv | 134 +++++++++++++
 tb/tb_sub_bytes_engine.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_if.sv
// Handshake and data bundle between the AES control FSM and the SubBytes engine.
// The controller side drives start/inv/in_data. The engine side returns the substituted state.
interface sub_bytes_if;
    logic         start;
    logic         inv;
    logic [127:0] in_data;
    logic [127:0] out_data;
    logic         busy;
    logic         done;

    modport master (output start, inv, in_data, input out_data, busy, done);
    modport slave  (input start, inv, in_data, output out_data, busy, done);
endinterface

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes / InvSubBytes engine: LANES bytes per beat through registered S-boxes.
//  state | meaning
//  IDLE  | waiting for start; out_data holds the last result
//  RUN   | issuing beats to the S-box stage and writing back results
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic  clk,
    input  logic  reset,
    sub_bytes_if.slave bus
);
    localparam int BEATS = 16 / LANES;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_chk
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    state_t             state;
    logic [127:0]       data_q;
    logic               inv_q;
    logic [IDX_W-1:0]   idx;
    logic               issue;
    logic [7:0]         rom_q [LANES];
    logic               rv;
    logic [IDX_W-1:0]   ridx;
    logic [127:0]       out_q;
    logic               busy_q;
    logic               done_q;

    assign bus.out_data = out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            data_q <= '0;
            inv_q  <= 1'b0;
            idx    <= '0;
            issue  <= 1'b0;
            rv     <= 1'b0;
            ridx   <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < LANES; i++) rom_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            rv     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_q <= bus.in_data;
                        inv_q  <= bus.inv;
                        idx    <= '0;
                        issue  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        for (int i = 0; i < LANES; i++)
                            rom_q[i] <= inv_q ? sbox_inv(data_q[(int'(idx)*LANES + i)*8 +: 8])
                                              : sbox_fwd(data_q[(int'(idx)*LANES + i)*8 +: 8]);
                        rv   <= 1'b1;
                        ridx <= idx;
                        if (idx == IDX_W'(BEATS - 1)) issue <= 1'b0;
                        else                          idx   <= idx + IDX_W'(1);
                    end
                    // writeback trails issue by one edge because of the registered ROM stage
                    if (rv) begin
                        for (int i = 0; i < LANES; i++)
                            out_q[(int'(ridx)*LANES + i)*8 +: 8] <= rom_q[i];
                        if (ridx == IDX_W'(BEATS - 1)) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine with LANES = 4, 1 and 16 instances side by side.
// Expected blocks are queued at start and compared when done rises.
module tb_sub_bytes_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sub_bytes_if bus4 ();
    sub_bytes_if bus1 ();
    sub_bytes_if bus16 ();

    sub_bytes_engine #(.LANES(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));
    sub_bytes_engine #(.LANES(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
    sub_bytes_engine #(.LANES(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

    int errors = 0;
    int checks = 0;
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    typedef struct { int d; logic [127:0] v; } exp_t;
    exp_t sbq [$];

    localparam logic [127:0] VEC_P = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_S = 128'hd42711aee0bf98f1b8b45de51e415230;

    function automatic int beats(input int d);
        case (d)
            0: return 4;
            1: return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [127:0] get_out(input int d);
        case (d)
            0: return bus4.out_data;
            1: return bus1.out_data;
            default: return bus16.out_data;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return bus4.busy;
            1: return bus1.busy;
            default: return bus16.busy;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0: return bus4.done;
            1: return bus1.done;
            default: return bus16.done;
        endcase
    endfunction

    task automatic drive(input int d, input logic s, input logic iv, input logic [127:0] dat);
        case (d)
            0: begin bus4.start = s;  bus4.inv = iv;  bus4.in_data = dat;  end
            1: begin bus1.start = s;  bus1.inv = iv;  bus1.in_data = dat;  end
            default: begin bus16.start = s; bus16.inv = iv; bus16.in_data = dat; end
        endcase
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference tables from log/antilog over generator 3 and a bitwise affine map
    task automatic build_model();
        int lg [256];
        int ex [256];
        logic [7:0] v, b, s, c;
        c = 8'h63;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = int'(v);
            lg[v] = i;
            v = v ^ xt(v);
        end
        for (int x = 0; x < 256; x++) begin
            b = (x == 0) ? 8'h00 : 8'(ex[(255 - lg[x]) % 255]);
            for (int k = 0; k < 8; k++)
                s[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8] ^ b[(k+7)%8] ^ c[k];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] dat, input logic iv);
        logic [127:0] r;
        for (int j = 0; j < 16; j++)
            r[8*j +: 8] = iv ? isb[dat[8*j +: 8]] : sb[dat[8*j +: 8]];
        return r;
    endfunction

    task automatic wait_done(input int d, output int cyc, output bit seen);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (get_done(d) === 1'b1) seen = 1;
        end
    endtask

    task automatic check_result(input int d, input int cyc, input bit seen, input int lat, input string name);
        exp_t e;
        e = sbq.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles, required %0d", name, cyc, lat);
        end else begin
            checks++;
            if (get_out(e.d) !== e.v) begin
                errors++;
                $display("FAIL %s data: got %h required %h", name, get_out(e.d), e.v);
            end
            checks++;
            if (cyc !== lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, cyc, lat);
            end
            checks++;
            if (get_busy(d) !== 1'b0) begin
                errors++;
                $display("FAIL %s busy at done: got %b required 0", name, get_busy(d));
            end
        end
    endtask

    task automatic run_block(input int d, input logic iv, input logic [127:0] dat,
                             input logic [127:0] expv, input string name);
        int cyc;
        bit seen;
        @(negedge clk);
        drive(d, 1'b1, iv, dat);
        sbq.push_back('{d, expv});
        @(negedge clk);
        drive(d, 1'b0, ~iv, rnd128());
        checks++;
        if (get_busy(d) !== 1'b1) begin
            errors++;
            $display("FAIL %s busy after start: got %b required 1", name, get_busy(d));
        end
        wait_done(d, cyc, seen);
        check_result(d, cyc, seen, beats(d) + 1, name);
        @(negedge clk);
        checks++;
        if (get_done(d) !== 1'b0) begin
            errors++;
            $display("FAIL %s done width: got %b required 0", name, get_done(d));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b0, rnd128());
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({get_out(d), get_busy(d), get_done(d)} !== 130'h0) begin
                    errors++;
                    $display("FAIL reset lanes=%0d: got out=%h busy=%b done=%b required 0/0/0",
                             16 / beats(d), get_out(d), get_busy(d), get_done(d));
                end
            end
        end
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, '0);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_busy(d) !== 1'b0) begin
                errors++;
                $display("FAIL reset release busy lanes=%0d: got %b required 0", 16 / beats(d), get_busy(d));
            end
        end
    endtask

    task automatic test_vectors();
        run_block(0, 1'b0, VEC_P, VEC_S, "fwd_vec");
        run_block(0, 1'b1, VEC_S, VEC_P, "inv_vec");
    endtask

    task automatic test_lanes();
        for (int d = 1; d < 3; d++) begin
            run_block(d, 1'b0, '0, {16{8'h63}}, $sformatf("zeros_l%0d", 16 / beats(d)));
            run_block(d, 1'b0, {16{8'h53}}, {16{8'hed}}, $sformatf("fifty3_l%0d", 16 / beats(d)));
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        bit seen;
        logic [127:0] a;
        a = rnd128();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, a);
        sbq.push_back('{0, model_sub(a, 1'b0)});
        @(negedge clk);
        drive(0, 1'b0, 1'b0, a);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, ~a);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, ~a);
        wait_done(0, cyc, seen);
        check_result(0, cyc + 2, seen, beats(0) + 1, "ignore_busy_start");
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        logic [127:0] a, b;
        for (int d = 0; d < 3; d++) begin
            a = rnd128();
            b = rnd128();
            @(negedge clk);
            drive(d, 1'b1, 1'b0, a);
            sbq.push_back('{d, model_sub(a, 1'b0)});
            @(negedge clk);
            drive(d, 1'b0, 1'b0, '0);
            wait_done(d, cyc, seen);
            check_result(d, cyc, seen, beats(d) + 1, $sformatf("b2b_first_l%0d", 16 / beats(d)));
            drive(d, 1'b1, 1'b1, b);
            sbq.push_back('{d, model_sub(b, 1'b1)});
            @(negedge clk);
            drive(d, 1'b0, 1'b0, rnd128());
            checks++;
            if ({get_busy(d), get_done(d)} !== 2'b10) begin
                errors++;
                $display("FAIL b2b accept l%0d: got busy=%b done=%b required 1/0",
                         16 / beats(d), get_busy(d), get_done(d));
            end
            wait_done(d, cyc, seen);
            check_result(d, cyc, seen, beats(d) + 1, $sformatf("b2b_second_l%0d", 16 / beats(d)));
        end
    endtask

    task automatic test_reset_mid();
        bit pulsed;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, VEC_P);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({get_out(0), get_busy(0), get_done(0)} !== 130'h0) begin
            errors++;
            $display("FAIL reset_mid: got out=%h busy=%b done=%b required 0/0/0",
                     get_out(0), get_busy(0), get_done(0));
        end
        pulsed = 0;
        repeat (8) begin
            @(negedge clk);
            if (get_done(0) !== 1'b0) pulsed = 1;
        end
        checks++;
        if (pulsed) begin
            errors++;
            $display("FAIL reset_mid done pulse: got 1 required 0");
        end
        run_block(0, 1'b0, VEC_P, VEC_S, "after_reset_mid");
    endtask

    task automatic test_random();
        logic [127:0] a;
        logic iv;
        for (int n = 0; n < 6; n++) begin
            a  = rnd128();
            iv = 1'($urandom_range(0, 1));
            run_block(n % 3, iv, a, model_sub(a, iv), $sformatf("random_%0d", n));
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_vectors();
        test_lanes();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
